// File: rtl/btn_ctrl_pkg.sv
// Shared constants and types for the push-button peripheral and the Bridge decode.
package btn_ctrl_pkg;

    // Board button count; also the width of both CPU-visible registers.
    localparam int unsigned DEFAULT_NUM_BTN = 5;

    // Byte addresses on the miniRV I/O bus.
    localparam logic [31:0] BTN_STATE_ADDR = 32'hFFFF_F078;
    localparam logic [31:0] BTN_EVENT_ADDR = 32'hFFFF_F07C;

    // Per-button debounce state.
    typedef enum logic [1:0] {
        DEB_LOW    = 2'd0,
        DEB_WAIT_H = 2'd1,
        DEB_HIGH   = 2'd2,
        DEB_WAIT_L = 2'd3
    } deb_state_t;

endpackage

// File: rtl/btn_ctrl_if.sv
// Bridge-to-button bus: address, write strobe, write data and combinational read data.
interface btn_ctrl_if;

    logic [31:0] addr_to_btn;
    logic        we_to_btn;
    logic [31:0] wdata_to_btn;
    logic [31:0] rdata_from_btn;

    modport master (
        output addr_to_btn,
        output we_to_btn,
        output wdata_to_btn,
        input  rdata_from_btn
    );

    modport slave (
        input  addr_to_btn,
        input  we_to_btn,
        input  wdata_to_btn,
        output rdata_from_btn
    );

endinterface

// File: rtl/btn_ctrl_debounce.sv
// One-button synchroniser and debouncer: a level change is accepted only after
// DEBOUNCE_CYCLES consecutive stable synchronised samples. 'rise' pulses on the
// clock edge where the accepted level goes from 0 to 1.
module btn_debounce
    import btn_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic stable,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1;
    logic             sync2;
    deb_state_t       state;
    deb_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             cnt_done;

    assign cnt_done = (cnt == CNT_LAST);

    // Two-flop synchroniser for the asynchronous button pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
        end
    end

    // Debounce state and stability counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DEB_LOW;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state, counter and output decode; counter tops out at DEBOUNCE_CYCLES-1.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        rise       = 1'b0;
        stable     = 1'b0;
        unique case (state)
            DEB_LOW: begin
                if (sync2) begin
                    state_next = DEB_WAIT_H;
                    cnt_next   = CNT_ONE;
                end
            end
            DEB_WAIT_H: begin
                if (!sync2) begin
                    state_next = DEB_LOW;
                    cnt_next   = '0;
                end else if (cnt_done) begin
                    state_next = DEB_HIGH;
                    cnt_next   = '0;
                    rise       = 1'b1;
                end else begin
                    cnt_next   = cnt + CNT_ONE;
                end
            end
            DEB_HIGH: begin
                stable = 1'b1;
                if (!sync2) begin
                    state_next = DEB_WAIT_L;
                    cnt_next   = CNT_ONE;
                end
            end
            DEB_WAIT_L: begin
                stable = 1'b1;
                if (sync2) begin
                    state_next = DEB_HIGH;
                    cnt_next   = '0;
                end else if (cnt_done) begin
                    state_next = DEB_LOW;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = DEB_LOW;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: rtl/btn_ctrl.sv
// Memory-mapped push-button peripheral: debounced live level (BTN_STATE, RO) and
// sticky per-button press events (BTN_EVENT, write-1-to-clear).
module btn_ctrl
    import btn_ctrl_pkg::*;
#(
    parameter int unsigned NUM_BTN         = DEFAULT_NUM_BTN,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic               clk_to_btn,
    input  logic               rst_to_btn,
    input  logic [NUM_BTN-1:0] button,
    btn_ctrl_if.slave          bus
);

    logic [NUM_BTN-1:0] stable;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] evt;
    logic [NUM_BTN-1:0] evt_clr;
    logic               unused_wdata_hi;

    // Upper write-data bits carry no register bits.
    assign unused_wdata_hi = ^bus.wdata_to_btn[31:NUM_BTN];

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_deb (
            .clk    (clk_to_btn),
            .rst    (rst_to_btn),
            .button (button[i]),
            .stable (stable[i]),
            .rise   (rise[i])
        );
    end

    // Clear mask from a bus write to BTN_EVENT.
    always_comb begin
        evt_clr = '0;
        if (bus.we_to_btn && (bus.addr_to_btn == BTN_EVENT_ADDR)) begin
            evt_clr = bus.wdata_to_btn[NUM_BTN-1:0];
        end
    end

    // Sticky event register; a new press on the same edge as a clear keeps the bit set.
    always_ff @(posedge clk_to_btn) begin
        if (rst_to_btn) begin
            evt <= '0;
        end else begin
            evt <= (evt & ~evt_clr) | rise;
        end
    end

    // Zero-wait read mux; unmapped addresses read as zero.
    always_comb begin
        bus.rdata_from_btn = '0;
        if (bus.addr_to_btn == BTN_STATE_ADDR) begin
            bus.rdata_from_btn = {{(32-NUM_BTN){1'b0}}, stable};
        end else if (bus.addr_to_btn == BTN_EVENT_ADDR) begin
            bus.rdata_from_btn = {{(32-NUM_BTN){1'b0}}, evt};
        end
    end

endmodule

// File: doc/btn_ctrl.md
# btn_ctrl

Memory-mapped push-button peripheral on the miniRV SoC I/O bus, placed directly downstream of the Bridge on its button port. Synchronises and debounces the five board buttons, then exposes two registers to the CPU: the live debounced level and a sticky per-button "pressed" event. Firmware clears event bits by writing 1 to them.

## Interface
Parameters:
- NUM_BTN, 5, number of button inputs (bits [NUM_BTN-1:0] of each register).
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a level change (10 ms at 25 MHz); minimum 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width.

Ports (one clock; reset is synchronous and active-high):
- clk_to_btn  in  1  peripheral clock from Bridge (CPU clock).
- rst_to_btn  in  1  synchronous active-high reset.
- button  in  NUM_BTN  raw, asynchronous button pins, 1 = pressed.
- addr_to_btn  in  32  bus byte address.
- we_to_btn  in  1  bus write strobe, sampled on rising edge.
- wdata_to_btn  in  32  bus write data.
- rdata_from_btn  out  32  bus read data, combinational from registers.

## Operation
- Register map (byte addresses): BTN_STATE = 0xFFFF_F078 (RO), BTN_EVENT = 0xFFFF_F07C (R/W1C).
- Read: addr = BTN_STATE -> {zeros, stable}; addr = BTN_EVENT -> {zeros, event}; any other address -> 0. Upper bits always 0.
- Per bit, two-flop synchroniser: sync1 <= button, sync2 <= sync1.
- Per-bit debounce FSM, states:
  - LOW: stable=0; sync2=1 -> WAIT_H, cnt <= 1.
  - WAIT_H: sync2=0 -> LOW, cnt <= 0; sync2=1 and cnt = DEBOUNCE_CYCLES-1 -> HIGH, cnt <= 0, rise pulse; else cnt++.
  - HIGH: stable=1; sync2=0 -> WAIT_L, cnt <= 1.
  - WAIT_L: mirror of WAIT_H, exit to LOW on count, to HIGH on sync2=1; no pulse.
- Event: event[i] set on the edge where rise[i] asserts (same edge stable[i] goes 1).
- W1C: we_to_btn=1 and addr = BTN_EVENT clears event[i] for each wdata_to_btn[i]=1; bits [31:NUM_BTN] ignored. Writes to BTN_STATE or other addresses ignored.
- Simultaneous rise and clear on the same bit: set wins (event stays 1).
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap possible.

## Timing
- Reset (edge with rst_to_btn=1): sync1/sync2=0, all FSMs LOW, cnt=0, stable=0, event=0; hence rdata_from_btn=0 for every address. Reset mid-count discards progress; a button held through reset is accepted as a fresh press after release of reset (stable rises, event sets).
- Press latency: button high before edge 0 and held -> sync2 high after edge 1 -> stable and event high after edge DEBOUNCE_CYCLES+1.
- Release latency identical; release never sets event.
- Glitch of fewer than DEBOUNCE_CYCLES sync2 cycles: no change to stable or event.
- Read is zero-wait, combinational; write takes effect at the sampling edge, visible on next read.

## Structure
- Add BTN_STATE_ADDR, BTN_EVENT_ADDR and NUM_BTN to shared defines.vh; Bridge decode uses the same constants.
- One sub-module: btn_debounce (synchroniser + FSM + counter for one bit, outputs stable and rise), instantiated NUM_BTN times via generate.
- btn_ctrl holds event register, W1C logic and read mux.

## Test plan
All with DEBOUNCE_CYCLES=4.
- Reset: assert rst_to_btn 2 cycles with button=5'b11111 -> both registers read 0; after release, stable=0x1F and event=0x1F at edge 5 post-reset.
- Clean press on button[2]: high before edge 0 -> BTN_STATE=0x04, BTN_EVENT=0x04 after edge 5, not before.
- Glitch: button[0] high for 3 cycles then low -> BTN_STATE and BTN_EVENT stay 0.
- W1C: event=0x05, write 0x01 to 0xFFFF_F07C -> BTN_EVENT=0x04; write 0xFFFF_FFE0 -> unchanged; write to 0xFFFF_F078 -> no effect.
- Set-vs-clear: W1C of bit 1 on the exact edge button[1] is accepted -> BTN_EVENT bit1 = 1.
- Release/bounce: held button[4] toggled low 2 cycles then high -> stable stays 1, no second event; full release -> BTN_STATE bit4=0 after 6 edges, event unchanged.
